// File: rtl/mac_frame_acc_pkg.sv
// Shared constants, types and width helper for the MAC frame accumulator.
package parameters;

  // MAC operand width; the MAC result stream is 2*N bits wide.
  localparam int N = 8;

  // Default number of samples summed into one frame.
  localparam int ACC_LEN = 16;

  // Accumulator control states.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Sum width: 2n result bits plus enough guard bits that len full-scale
  // samples can never overflow. At least one guard bit is kept even for len=1.
  function automatic int acc_width(input int n, input int len);
    int g;
    g = $clog2(len);
    if (g < 1) begin
      g = 1;
    end
    return 2 * n + g;
  endfunction

endpackage

// File: rtl/mac_frame_acc.sv
// Frame accumulator: sums LEN accepted MAC results and holds the total
// on a registered valid/ready output until the consumer takes it.
module mac_frame_acc
  import parameters::*;
#(
  parameter int N   = parameters::N,
  parameter int LEN = ACC_LEN,
  localparam int W  = acc_width(N, LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [2*N-1:0]   in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [15:0]      frame_cnt
);

  // Index of the last sample in a frame.
  localparam logic [15:0] LAST = 16'(LEN - 1);

  acc_state_t      state_r;
  logic [W-1:0]    acc_r;
  logic [15:0]     cnt_r;
  logic [W-1:0]    sample_ext;

  // Zero-extend the incoming sample to the sum width.
  assign sample_ext = {{(W - 2 * N){1'b0}}, in_data};

  // Ready depends only on state, so no combinational path from in_valid or
  // out_ready; it is forced low while reset is asserted.
  assign in_ready = (state_r == ACCUM) && !reset;

  // Frame FSM, sample counter, accumulator and registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ACCUM;
      acc_r     <= {W{1'b0}};
      cnt_r     <= 16'd0;
      out_data  <= {W{1'b0}};
      out_valid <= 1'b0;
      frame_cnt <= 16'd0;
    end else if (clear) begin
      // Abort wins over any simultaneous accept or handoff; the completed
      // frame count is preserved.
      state_r   <= ACCUM;
      acc_r     <= {W{1'b0}};
      cnt_r     <= 16'd0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          // in_ready is high here because reset is low and state is ACCUM.
          if (in_valid) begin
            if (cnt_r == LAST) begin
              out_data  <= acc_r + sample_ext;
              out_valid <= 1'b1;
              acc_r     <= {W{1'b0}};
              cnt_r     <= 16'd0;
              state_r   <= HOLD;
            end else begin
              acc_r <= acc_r + sample_ext;
              cnt_r <= cnt_r + 16'd1;
            end
          end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            state_r   <= ACCUM;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= ACCUM;
          acc_r     <= {W{1'b0}};
          cnt_r     <= 16'd0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_frame_acc.sv
// Directed, table-driven bench for mac_frame_acc with N=8, LEN=4 (W=18).
module tb_mac_frame_acc;

  localparam int N   = 8;
  localparam int LEN = 4;
  localparam int W   = 18;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [15:0]   frame_cnt;

  int checks;
  int errors;

  typedef struct {
    logic         iv;
    logic [15:0]  d;
    logic         ordy;
    logic         clr;
    logic         e_ir;
    logic         e_ov;
    logic [17:0]  e_od;
    logic [15:0]  e_fc;
  } vec_t;

  vec_t vecs[$];

  mac_frame_acc #(.N(N), .LEN(LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input int d, input logic ordy, input logic clr,
                     input logic ir, input logic ov, input int od, input int fc);
    vec_t v;
    v.iv = iv; v.d = 16'(d); v.ordy = ordy; v.clr = clr;
    v.e_ir = ir; v.e_ov = ov; v.e_od = 18'(od); v.e_fc = 16'(fc);
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let one edge pass, then check outputs.
  task automatic step(input logic iv, input int d, input logic ordy,
                      input logic ir, input logic ov, input int od, input int fc,
                      input string tag);
    in_valid  = iv;
    in_data   = 16'(d);
    out_ready = ordy;
    clear     = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(od));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(fc));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"},  32'(out_data),  32'd0);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // T1: basic frame 10+20+30+40 with consumer always ready
    add(1, 10, 1, 0,  1, 0, 0, 0);
    add(1, 20, 1, 0,  1, 0, 0, 0);
    add(1, 30, 1, 0,  1, 0, 0, 0);
    add(1, 40, 1, 0,  0, 1, 100, 0);
    add(0, 0,  1, 0,  1, 0, 100, 1);
    // T2: full-scale samples, then a handoff with an ignored sample, then 1s
    add(1, 65535, 1, 0,  1, 0, 100, 1);
    add(1, 65535, 1, 0,  1, 0, 100, 1);
    add(1, 65535, 1, 0,  1, 0, 100, 1);
    add(1, 65535, 1, 0,  0, 1, 262140, 1);
    add(1, 77,    1, 0,  1, 0, 262140, 2);
    add(1, 1, 1, 0,  1, 0, 262140, 2);
    add(1, 1, 1, 0,  1, 0, 262140, 2);
    add(1, 1, 1, 0,  1, 0, 262140, 2);
    add(1, 1, 1, 0,  0, 1, 4, 2);
    add(0, 0, 1, 0,  1, 0, 4, 3);
    // T3: back-pressure in HOLD for 5 cycles while upstream keeps offering data
    add(1, 10, 0, 0,  1, 0, 4, 3);
    add(1, 20, 0, 0,  1, 0, 4, 3);
    add(1, 30, 0, 0,  1, 0, 4, 3);
    add(1, 40, 0, 0,  0, 1, 100, 3);
    for (int i = 0; i < 5; i++) add(1, 55, 0, 0,  0, 1, 100, 3);
    add(1, 55, 1, 0,  1, 0, 100, 4);
    add(1, 1, 0, 0,  1, 0, 100, 4);
    add(1, 2, 0, 0,  1, 0, 100, 4);
    add(1, 3, 0, 0,  1, 0, 100, 4);
    add(1, 4, 0, 0,  0, 1, 10, 4);
    add(0, 0, 1, 0,  1, 0, 10, 5);
    // T4: bubbles between samples 5,_,7,_,_,9,11
    add(1, 5,  1, 0,  1, 0, 10, 5);
    add(0, 0,  1, 0,  1, 0, 10, 5);
    add(1, 7,  1, 0,  1, 0, 10, 5);
    add(0, 0,  1, 0,  1, 0, 10, 5);
    add(0, 0,  1, 0,  1, 0, 10, 5);
    add(1, 9,  1, 0,  1, 0, 10, 5);
    add(1, 11, 1, 0,  0, 1, 32, 5);
    add(0, 0,  1, 0,  1, 0, 32, 6);
    // T5: clear mid-frame with a simultaneous sample, then clear in HOLD
    add(1, 100, 1, 0,  1, 0, 32, 6);
    add(1, 200, 1, 0,  1, 0, 32, 6);
    add(1, 999, 1, 1,  1, 0, 32, 6);
    add(1, 1, 0, 0,  1, 0, 32, 6);
    add(1, 2, 0, 0,  1, 0, 32, 6);
    add(1, 3, 0, 0,  1, 0, 32, 6);
    add(1, 4, 0, 0,  0, 1, 10, 6);
    add(0, 0, 1, 1,  1, 0, 10, 6);
    add(1, 2, 1, 0,  1, 0, 10, 6);
    add(1, 2, 1, 0,  1, 0, 10, 6);
    add(1, 2, 1, 0,  1, 0, 10, 6);
    add(1, 2, 1, 0,  0, 1, 8, 6);
    add(0, 0, 1, 0,  1, 0, 8, 7);

    // Reset state
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_release.in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      clear     = vecs[i].clr;
      @(posedge clk);
      #1;
      chk({tag, ".in_ready"},  32'(in_ready),  32'(vecs[i].e_ir));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(vecs[i].e_ov));
      chk({tag, ".out_data"},  32'(out_data),  32'(vecs[i].e_od));
      chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(vecs[i].e_fc));
    end
    clear = 1'b0;

    // T6a: asynchronous reset mid-frame after two samples
    step(1, 5, 0,  1, 0, 8, 7, "t6_s0");
    step(1, 6, 0,  1, 0, 8, 7, "t6_s1");
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("t6_async_mid");
    @(negedge clk);
    reset = 1'b0;
    // Partial sum lost: three more samples must not complete a frame
    step(1, 3, 0,  1, 0, 0, 0, "t6_a0");
    step(1, 3, 0,  1, 0, 0, 0, "t6_a1");
    step(1, 3, 0,  1, 0, 0, 0, "t6_a2");
    step(1, 3, 0,  0, 1, 12, 0, "t6_a3");
    // T6b: asynchronous reset during HOLD
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("t6_async_hold");
    @(negedge clk);
    reset = 1'b0;
    step(1, 3, 0,  1, 0, 0, 0, "t6_b0");
    step(1, 3, 0,  1, 0, 0, 0, "t6_b1");
    step(1, 3, 0,  1, 0, 0, 0, "t6_b2");
    step(1, 3, 0,  0, 1, 12, 0, "t6_b3");
    step(0, 0, 1,  1, 0, 12, 1, "t6_b4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_frame_acc.md
Name: mac_frame_acc

Overview:
Downstream stage of the A*B+C multiply-add pipeline. Consumes the 2N-bit MAC result stream under a valid/ready handshake and sums LEN consecutive accepted samples into one frame total. Presents the total on a registered valid/ready output and holds it until it is taken. Feeds the frame-level consumer, such as readout or an averaging divider.

Parameters:
N, parameters::N (8), MAC operand width; input samples are 2N bits.
LEN, 16, samples per frame; legal range 1..65535.
G, $clog2(LEN) (minimum 1), guard bits; sum width W = 2N+G.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort of the current frame and any held result
in_valid  in  1  in_data is valid this cycle
in_data  in  2N  unsigned MAC result
in_ready  out  1  block accepts in_data this cycle
out_valid  out  1  out_data holds a completed frame sum
out_data  out  W  unsigned frame sum
out_ready  in  1  consumer takes out_data this cycle
frame_cnt  out  16  completed frames handed off; wraps 65535->0

Behaviour:
- Reset: state=ACCUM; acc, cnt, out_data, out_valid, frame_cnt all 0. in_ready=0 while reset is high. Reset takes effect immediately, including mid-frame and in HOLD; the partial sum is lost.
- States: ACCUM, HOLD. Typedef acc_state_t.
- in_ready = (state==ACCUM) && !reset. It is combinational from state only, with no path from in_valid or out_ready.
- Accept = in_valid && in_ready. Bubbles (in_valid=0) leave acc and cnt unchanged.
- ACCUM, accept with cnt<LEN-1: acc <= acc + zero-extended in_data; cnt++.
- ACCUM, accept with cnt==LEN-1:
  - out_data <= acc + in_data; out_valid <= 1.
  - acc <= 0; cnt <= 0; state <= HOLD.
  - Latency: out_valid rises on the clock edge after the last sample is accepted.
- HOLD: out_valid=1 and out_data stable; no input is accepted.
  - On out_ready=1: out_valid <= 0; frame_cnt++; state <= ACCUM.
  - Earliest next-frame accept is the cycle after the handoff.
  - Maximum throughput: one frame per LEN+1 cycles.
- out_ready while out_valid=0 has no effect.
- Arithmetic: unsigned only, no saturation. W guarantees LEN*(2^(2N)-1) fits, so overflow is impossible by construction.
- LEN=1: every accepted sample goes straight to HOLD with out_data = in_data.
- clear=1 in any state:
  - acc, cnt, out_valid go to 0; state <= ACCUM; frame_cnt is unchanged.
  - clear wins over a simultaneous accept (the sample is dropped) and over a simultaneous out_ready (no handoff counted).
  - in_ready still follows the current state during the clear cycle. The upstream sees a handshake that the block discards.

Decomposition:
- Package parameters adds:
  - ACC_LEN constant (default 16).
  - Function acc_width(n, len) returning 2n + max(1, clog2(len)).
  - Typedef acc_state_t {ACCUM, HOLD}.
- No sub-module. Counter, accumulator and FSM are a single always_ff plus the in_ready assign.

Test Plan (N=8, LEN=4, W=18):
1. Reset, then in_data 10,20,30,40 on consecutive cycles with out_ready=1 -> out_valid=1 for one cycle, one edge after the 4th accept; out_data=100; frame_cnt=1; in_ready=0 for exactly that cycle.
2. Four samples of 65535 -> out_data=262140 (0x3FFFC), no wrap; then 1,1,1,1 -> out_data=4, showing acc was cleared between frames.
3. Complete a frame with out_ready=0 for 5 cycles and in_valid=1 throughout -> out_valid and out_data=100 held stable, in_ready=0, no samples consumed; raise out_ready -> frame_cnt increments and the next 4 samples form a fresh sum.
4. Samples 5,_,7,_,_,9,11 (_ = in_valid=0) -> out_data=32, after the same number of accepts as with no bubbles.
5. Accept 100,200, then clear together with in_valid=1 (sample 999), then 1,2,3,4 -> out_data=10, frame_cnt unchanged by the clear; clear asserted in HOLD drops out_valid with no frame_cnt increment.
6. Assert reset asynchronously mid-frame (after 2 samples) and again during HOLD -> all outputs 0 before the next clk edge, in_ready=0 during reset; after release, 4 samples of 3 give out_data=12, frame_cnt=1.
